mc_lsu: RTL and testbench

Parametrised multicycle load/store unit for the multicycle RISC-V core. It replaces the single-cycle, combinational data-memory path with a request/grant/rvalid memory bus that can stall. The unit splits misaligned accesses into two aligned bus beats and returns sign- or zero-extended load data. The control FSM starts it in the memory-access state and waits on done_o before write-back.

---
 rtl/mc_lsu_if.sv | 27 ++
 rtl/mc_lsu.sv | 170 +++++++++++++++++
 tb/tb_mc_lsu.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_lsu_if.sv
// Memory bus bundle for the multicycle load/store unit.
// Request/grant/rvalid bus: master drives req/we/addr/be/wdata,
// slave returns gnt, rvalid and rdata.
interface mc_lsu_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mc_lsu.sv
// Multicycle load/store unit: splits boundary-crossing accesses
// into two aligned beats on a req/gnt/rvalid bus, one beat in flight.
// Ports: clk_i, rst_i (sync, active high), start_i/we_i/funct3_i/
// addr_i/wdata_i request; busy_o/done_o/err_o/rdata_o status; mem bus.
module mc_lsu #(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [XLEN-1:0] rdata_o,
    mc_lsu_if.master        mem
);
    localparam int NB   = XLEN / 8;
    localparam int LB   = $clog2(NB);
    localparam bit IS32 = (XLEN == 32);
    localparam logic [2*NB-1:0] ONE2 = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_beat0;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    // Access spills into the next beat when its last byte passes NB.
    function automatic logic f_cross(input logic [LB-1:0] off,
                                     input logic [1:0] sz2);
        return (5'(off) + (5'd1 << sz2)) > 5'(NB);
    endfunction

    logic w_ill;
    logic w_bad;
    assign w_ill = (IS32 && funct3_i[1:0] == 2'b11)
                 || (!we_i && funct3_i == 3'b111)
                 || (!we_i && IS32 && funct3_i == 3'b110);
    assign w_bad = w_ill
                 || (!MISALIGN_EN && f_cross(addr_i[LB-1:0], funct3_i[1:0]));

    logic [LB-1:0]      w_off;
    logic [3:0]         w_sz;
    logic               w_cross;
    logic [XLEN-1:0]    w_a0;
    logic [XLEN-1:0]    w_a1;
    logic [2*NB-1:0]    w_be2;
    logic [2*XLEN-1:0]  w_wd2;

    assign w_off   = r_addr[LB-1:0];
    assign w_sz    = 4'd1 << r_f3[1:0];
    assign w_cross = f_cross(w_off, r_f3[1:0]);
    assign w_a0    = {r_addr[XLEN-1:LB], {LB{1'b0}}};
    assign w_a1    = w_a0 + XLEN'(NB);
    assign w_be2   = ((ONE2 << w_sz) - ONE2) << w_off;
    assign w_wd2   = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};

    // Final beat is taken straight off the bus so the extended result
    // can be registered in the same cycle as the last rvalid.
    logic [XLEN-1:0]        w_b0;
    logic [XLEN-1:0]        w_lo;
    logic [6:0]             w_k;
    logic [XLEN-1:0]        w_shl;
    logic signed [XLEN-1:0] w_sra;
    logic [XLEN-1:0]        w_ext;
    logic                   w_last;

    assign w_b0   = (r_state == S_WAIT0) ? mem.rdata : r_beat0;
    assign w_lo   = XLEN'({mem.rdata, w_b0} >> {w_off, 3'b000});
    assign w_k    = 7'(XLEN) - {w_sz, 3'b000};
    assign w_shl  = w_lo << w_k;
    assign w_sra  = $signed(w_shl) >>> w_k;
    assign w_ext  = r_f3[2] ? (w_shl >> w_k) : w_sra;
    assign w_last = mem.rvalid && !r_we
                  && ((r_state == S_WAIT0 && !w_cross)
                  || r_state == S_WAIT1);

    always_comb begin
        w_next    = r_state;
        mem.req   = 1'b0;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.be    = '0;
        mem.wdata = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i && !w_bad)
                    w_next = S_REQ0;
            end
            S_REQ0: begin
                mem.req   = 1'b1;
                mem.we    = r_we;
                mem.addr  = w_a0;
                mem.be    = w_be2[NB-1:0];
                mem.wdata = w_wd2[XLEN-1:0];
                if (mem.gnt) begin
                    if (!r_we)
                        w_next = S_WAIT0;
                    else if (w_cross)
                        w_next = S_REQ1;
                    else
                        w_next = S_FIN;
                end
            end
            S_WAIT0: begin
                if (mem.rvalid)
                    w_next = w_cross ? S_REQ1 : S_FIN;
            end
            S_REQ1: begin
                mem.req   = 1'b1;
                mem.we    = r_we;
                mem.addr  = w_a1;
                mem.be    = w_be2[2*NB-1:NB];
                mem.wdata = w_wd2[2*XLEN-1:XLEN];
                if (mem.gnt)
                    w_next = r_we ? S_FIN : S_WAIT1;
            end
            S_WAIT1: begin
                if (mem.rvalid)
                    w_next = S_FIN;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_beat0 <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == S_IDLE) && start_i && w_bad;
            if (r_state == S_IDLE && start_i) begin
                r_we    <= we_i;
                r_f3    <= funct3_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (r_state == S_WAIT0 && mem.rvalid)
                r_beat0 <= mem.rdata;
            if (w_last)
                r_rdata <= w_ext;
        end
    end

    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_FIN);
    assign err_o   = r_err;
    assign rdata_o = r_rdata;
endmodule

// File: tb/tb_mc_lsu.sv
// Directed bench for mc_lsu with a word memory bus responder.
// Table vectors plus delayed-grant, no-split and reset sequences.
module tb_mc_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_nm = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        busy_nm, done_nm, err_nm;
    logic [31:0] rdata_nm;

    int checks = 0;
    int errors = 0;

    mc_lsu_if #(.XLEN(32)) bus ();
    mc_lsu_if #(.XLEN(32)) bus_nm ();

    mc_lsu #(.XLEN(32), .MISALIGN_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .we_i(we),
        .funct3_i(f3), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata),
        .mem(bus)
    );

    mc_lsu #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_nm (
        .clk_i(clk), .rst_i(rst), .start_i(start_nm), .we_i(we),
        .funct3_i(f3), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy_nm), .done_o(done_nm), .err_o(err_nm),
        .rdata_o(rdata_nm), .mem(bus_nm)
    );

    always #5 clk = ~clk;

    assign bus_nm.gnt    = 1'b1;
    assign bus_nm.rvalid = 1'b0;
    assign bus_nm.rdata  = '0;

    int nm_reqs = 0;
    always @(posedge clk) if (bus_nm.req) nm_reqs++;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } beat_t;
    beat_t beats[$];

    logic [31:0] mem [0:127];
    int          gnt_dly = 0;
    int          gcnt = 0;
    int          blk_idx = -1;
    logic        pend = 1'b0;
    logic [31:0] pa = '0;
    logic        late_pend = 1'b0;
    logic        late_fire = 1'b0;
    logic [31:0] late_a = '0;

    always @(posedge clk) begin
        if (bus.req && bus.gnt) begin
            beats.push_back('{bus.addr, bus.be, bus.wdata, bus.we});
            gcnt = 0;
            if (bus.we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.be[i])
                        mem[bus.addr[8:2]][8*i +: 8] = bus.wdata[8*i +: 8];
            end else if (beats.size() - 1 == blk_idx) begin
                late_pend = 1'b1;
                late_a    = bus.addr;
            end else begin
                pend = 1'b1;
                pa   = bus.addr;
            end
        end else if (bus.req) begin
            gcnt++;
        end
    end

    always @(negedge clk) begin
        bus.gnt = bus.req && (gcnt >= gnt_dly);
        if (pend) begin
            bus.rvalid = 1'b1;
            bus.rdata  = mem[pa[8:2]];
            pend       = 1'b0;
        end else if (late_fire && late_pend) begin
            bus.rvalid = 1'b1;
            bus.rdata  = mem[late_a[8:2]];
            late_pend  = 1'b0;
            late_fire  = 1'b0;
        end else begin
            bus.rvalid = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          gd;
        logic        xerr;
        int          xlat;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] xrd;
    } vec_t;
    vec_t v[11];

    task automatic wait_end(output int n, output logic gd,
                            output logic ge);
        n  = -1;
        gd = 1'b0;
        ge = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done || err) begin
                n  = k;
                gd = done;
                ge = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_acc(input vec_t t, output int n, output logic gd,
                           output logic ge, output logic [1:0] post);
        beats.delete();
        gnt_dly = t.gd;
        gcnt    = 0;
        @(negedge clk);
        start = 1'b1;
        we    = t.we;
        f3    = t.f3;
        addr  = t.a;
        wdata = t.wd;
        @(negedge clk);
        start = 1'b0;
        wait_end(n, gd, ge);
        @(negedge clk);
        post = {done, err};
    endtask

    int         n;
    logic       gd, ge;
    logic [1:0] post;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[32'h100 >> 2] = 32'h8765_4321;
        mem[1] = 32'h1122_3344;
        mem[2] = 32'h5566_7792;

        // we f3 a wd gd xerr xlat nb a0 be0 wd0 a1 be1 wd1 xrd
        v[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 3, 1,
                  32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h8765_4321};
        v[1]  = '{1'b1, 3'b000, 32'h103, 32'h80, 0, 1'b0, 2, 1,
                  32'h100, 4'h8, 32'h8000_0000, 32'h0, 4'h0, 32'h0,
                  32'h8765_4321};
        v[2]  = '{1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0, 3, 1,
                  32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF_FF80};
        v[3]  = '{1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0, 3, 1,
                  32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_0080};
        v[4]  = '{1'b0, 3'b101, 32'h7, 32'h0, 0, 1'b0, 5, 2,
                  32'h4, 4'h8, 32'h0, 32'h8, 4'h1, 32'h0, 32'h0000_9211};
        v[5]  = '{1'b1, 3'b010, 32'h6, 32'hAABB_CCDD, 0, 1'b0, 3, 2,
                  32'h4, 4'hC, 32'hCCDD_0000, 32'h8, 4'h3, 32'h0000_AABB,
                  32'h0000_9211};
        v[6]  = '{1'b0, 3'b010, 32'h6, 32'h0, 1, 1'b0, -1, 2,
                  32'h4, 4'hC, 32'h0, 32'h8, 4'h3, 32'h0, 32'hAABB_CCDD};
        v[7]  = '{1'b0, 3'b011, 32'h0, 32'h0, 0, 1'b1, 1, 0,
                  32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hAABB_CCDD};
        v[8]  = '{1'b0, 3'b110, 32'h0, 32'h0, 0, 1'b1, 1, 0,
                  32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hAABB_CCDD};
        v[9]  = '{1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 0, 1'b0, 2, 1,
                  32'h100, 4'hC, 32'hBEEF_0000, 32'h0, 4'h0, 32'h0,
                  32'hAABB_CCDD};
        v[10] = '{1'b0, 3'b001, 32'h102, 32'h0, 2, 1'b0, 5, 1,
                  32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF_BEEF};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs",
            32'(|{busy, done, err, rdata, bus.req, bus.we,
                  bus.addr, bus.be, bus.wdata}), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_acc(v[i], n, gd, ge, post);
            if (v[i].xlat >= 0)
                chk($sformatf("v%0d_lat", i), 32'(n), 32'(v[i].xlat));
            chk($sformatf("v%0d_done", i), 32'(gd), 32'(!v[i].xerr));
            chk($sformatf("v%0d_err", i), 32'(ge), 32'(v[i].xerr));
            chk($sformatf("v%0d_pulse", i), 32'(post), 32'd0);
            chk($sformatf("v%0d_nbeats", i), 32'(beats.size()),
                32'(v[i].nb));
            if (v[i].nb >= 1 && beats.size() >= 1) begin
                chk($sformatf("v%0d_a0", i), beats[0].a, v[i].a0);
                chk($sformatf("v%0d_be0", i), 32'(beats[0].be),
                    32'(v[i].be0));
                chk($sformatf("v%0d_wd0", i), beats[0].wd, v[i].wd0);
                chk($sformatf("v%0d_we0", i), 32'(beats[0].we),
                    32'(v[i].we));
            end
            if (v[i].nb >= 2 && beats.size() >= 2) begin
                chk($sformatf("v%0d_a1", i), beats[1].a, v[i].a1);
                chk($sformatf("v%0d_be1", i), 32'(beats[1].be),
                    32'(v[i].be1));
                chk($sformatf("v%0d_wd1", i), beats[1].wd, v[i].wd1);
            end
            chk($sformatf("v%0d_rdata", i), rdata, v[i].xrd);
        end

        // Misaligned LH with three-cycle grant stall; a second start
        // during the stall must be ignored.
        mem[1] = 32'h1122_3344;
        mem[2] = 32'h5566_7792;
        beats.delete();
        gnt_dly = 3;
        gcnt    = 0;
        @(negedge clk);
        start = 1'b1; we = 1'b0; f3 = 3'b001; addr = 32'h7; wdata = '0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("dly_req", 32'(bus.req), 32'd1);
            chk("dly_addr", bus.addr, 32'h4);
            chk("dly_be", 32'(bus.be), 32'h8);
            chk("dly_busy", 32'(busy), 32'd1);
            start = (k == 0);
            addr  = (k == 0) ? 32'h100 : 32'h7;
            f3    = (k == 0) ? 3'b010 : 3'b001;
            @(negedge clk);
        end
        start = 1'b0;
        wait_end(n, gd, ge);
        chk("dly_done", 32'(gd), 32'd1);
        chk("dly_rdata", rdata, 32'hFFFF_9211);
        chk("dly_nbeats", 32'(beats.size()), 32'd2);
        if (beats.size() >= 2) begin
            chk("dly_a1", beats[1].a, 32'h8);
            chk("dly_be1", 32'(beats[1].be), 32'h1);
        end

        // No-split instance: misaligned LW flags err without bus use.
        @(negedge clk);
        nm_reqs  = 0;
        start_nm = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h2;
        @(negedge clk);
        start_nm = 1'b0;
        chk("nm_err", 32'(err_nm), 32'd1);
        chk("nm_done", 32'(done_nm), 32'd0);
        @(negedge clk);
        chk("nm_err_pulse", 32'(err_nm), 32'd0);
        @(negedge clk);
        chk("nm_noreq", 32'(nm_reqs), 32'd0);
        start_nm = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h0;
        wdata = 32'h5;
        @(negedge clk);
        start_nm = 1'b0;
        chk("nm_sw_be", 32'(bus_nm.be), 32'hF);
        @(negedge clk);
        chk("nm_sw_done", 32'(done_nm), 32'd1);
        chk("nm_sw_reqs", 32'(nm_reqs), 32'd1);

        // Reset while waiting on the second load beat.
        mem[1]  = 32'h1122_3344;
        mem[2]  = 32'h5566_7792;
        blk_idx = 1;
        gnt_dly = 0;
        gcnt    = 0;
        beats.delete();
        @(negedge clk);
        start = 1'b1; we = 1'b0; f3 = 3'b001; addr = 32'h7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (beats.size() >= 2) break;
            @(negedge clk);
        end
        chk("rs_beats", 32'(beats.size()), 32'd2);
        chk("rs_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        late_fire = 1'b1;
        blk_idx   = -1;
        @(negedge clk);
        chk("rs_outs",
            32'(|{busy, done, err, rdata, bus.req, bus.we,
                  bus.addr, bus.be, bus.wdata}), 32'd0);
        @(negedge clk);
        chk("rs_late_flags", 32'({busy, done, err}), 32'd0);
        chk("rs_late_rdata", rdata, 32'd0);
        run_acc(v[0], n, gd, ge, post);
        chk("rs_lw_lat", 32'(n), 32'd3);
        chk("rs_lw_rdata", rdata, 32'hBEEF_4321);
        chk("rs_lw_nbeats", 32'(beats.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
